// File: rtl/mem_ctrl.sv
// mem_ctrl: accepts one cache-line READ/WRITE and runs it as HOST_W-wide beats on the host bus.
// Latency: read >= BEATS+2 cycles accept->tx_done, write >= BEATS+1; host stalls add cycles 1:1.
// Backpressure: ready low while busy; host_req payload held while host_req_rdy=0. Option: MEM_CTRL_TIMEOUT_EN.
module mem_ctrl #(
  parameter int LINE_W  = 512,
  parameter int HOST_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [LINE_W-1:0] mem_wr_data,
  output logic              ready,
  output logic              tx_done,
  output logic [LINE_W-1:0] mem_rd_data,
  input  logic [63:0]       host_base,
  output logic              host_req_valid,
  input  logic              host_req_rdy,
  output logic              host_req_wr,
  output logic [63:0]       host_req_addr,
  output logic [HOST_W-1:0] host_req_data,
  input  logic              host_rsp_valid,
  input  logic [HOST_W-1:0] host_rsp_data,
  output logic              err
);

  localparam int BEATS = LINE_W / HOST_W;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam logic [63:0]   STEP = 64'(HOST_W / 8);
  localparam logic [KW-1:0] LAST = KW'(BEATS - 1);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BEAT, DONE} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [LINE_W-1:0] wr_line;   // remaining write beats, beat k+1 sits in the second slice
  logic [31:0]       line_addr;
  logic              unused_addr_bits;

  // Byte offset within the line is irrelevant to a whole-line transfer
  assign line_addr        = {mem_addr[31:OFF], {OFF{1'b0}}};
  assign unused_addr_bits = ^mem_addr[OFF-1:0];

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          stall;
  logic          tmo_hit;

  // A wait cycle is any cycle where the host has not completed the handshake we are waiting on
  assign stall   = ((state == RD_REQ || state == WR_BEAT) && !host_req_rdy) ||
                   ((state == RD_DATA) && !host_rsp_valid);
  assign tmo_hit = stall && (tmo_cnt == TW'(TIMEOUT - 1));

  // Wait-cycle counter, cleared by every handshake and by the timeout itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (!stall || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  assign err = 1'b0;
`endif

  // Main controller FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      k              <= '0;
      wr_line        <= '0;
      ready          <= 1'b1;
      tx_done        <= 1'b0;
      mem_rd_data    <= '0;
      host_req_valid <= 1'b0;
      host_req_wr    <= 1'b0;
      host_req_addr  <= '0;
      host_req_data  <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
      err            <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
      if (tmo_hit) begin
        // Abandon the op: unread beats stay 0 because the line was cleared at accept
        err            <= 1'b1;
        host_req_valid <= 1'b0;
        host_req_wr    <= 1'b0;
        k              <= '0;
        tx_done        <= 1'b1;
        state          <= DONE;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            if (mem_op == OP_READ) begin
              ready          <= 1'b0;
              mem_rd_data    <= '0;
              host_req_valid <= 1'b1;
              host_req_wr    <= 1'b0;
              host_req_addr  <= host_base + {32'b0, line_addr};
              k              <= '0;
              state          <= RD_REQ;
            end else if (mem_op == OP_WRITE) begin
              ready          <= 1'b0;
              wr_line        <= mem_wr_data;
              host_req_valid <= 1'b1;
              host_req_wr    <= 1'b1;
              host_req_addr  <= host_base + {32'b0, line_addr};
              host_req_data  <= mem_wr_data[HOST_W-1:0];
              k              <= '0;
              state          <= WR_BEAT;
            end
          end
          RD_REQ: begin
            // A single request covers the whole line
            if (host_req_rdy) begin
              host_req_valid <= 1'b0;
              state          <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (host_rsp_valid) begin
              mem_rd_data[int'(k)*HOST_W +: HOST_W] <= host_rsp_data;
              if (k == LAST) begin
                k       <= '0;
                tx_done <= 1'b1;
                state   <= DONE;
              end else begin
                k <= k + 1'b1;
              end
            end
          end
          WR_BEAT: begin
            if (host_req_rdy) begin
              if (k == LAST) begin
                host_req_valid <= 1'b0;
                host_req_wr    <= 1'b0;
                k              <= '0;
                tx_done        <= 1'b1;
                state          <= DONE;
              end else begin
                k             <= k + 1'b1;
                host_req_addr <= host_req_addr + STEP;
                host_req_data <= wr_line[2*HOST_W-1:HOST_W];
                wr_line       <= wr_line >> HOST_W;
              end
            end
          end
          DONE: begin
            ready <= 1'b1;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: reset, read, write with host stalls, reserved op,
// mid-operation reset and long host stall (timeout when MEM_CTRL_TIMEOUT_EN is defined).
module tb_mem_ctrl;

  localparam int LINE_W = 512;
  localparam int HOST_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mem_op;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wr_data;
  logic              ready;
  logic              tx_done;
  logic [LINE_W-1:0] mem_rd_data;
  logic [63:0]       host_base;
  logic              host_req_valid;
  logic              host_req_rdy;
  logic              host_req_wr;
  logic [63:0]       host_req_addr;
  logic [HOST_W-1:0] host_req_data;
  logic              host_rsp_valid;
  logic [HOST_W-1:0] host_rsp_data;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.LINE_W(LINE_W), .HOST_W(HOST_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .ready(ready), .tx_done(tx_done),
    .mem_rd_data(mem_rd_data), .host_base(host_base),
    .host_req_valid(host_req_valid), .host_req_rdy(host_req_rdy),
    .host_req_wr(host_req_wr), .host_req_addr(host_req_addr),
    .host_req_data(host_req_data), .host_rsp_valid(host_rsp_valid),
    .host_rsp_data(host_rsp_data), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int beat;
    logic [LINE_W-1:0] line;

    rst_n          = 1'b0;
    mem_op         = 2'b01;
    mem_addr       = 32'h0001_0040;
    mem_wr_data    = '0;
    host_base      = 64'h1_0000_0000;
    host_req_rdy   = 1'b1;
    host_rsp_valid = 1'b0;
    host_rsp_data  = '0;

    // Reset held with READ presented: nothing may start
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", host_req_valid, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_err", err, 0);
    check("rst_wr", host_req_wr, 0);
    check("rst_addr", host_req_addr, 0);
    check("rst_rd_lo", mem_rd_data[63:0], 0);

    // Release: READ accepted on the first edge
    rst_n = 1'b1;
    @(negedge clk);
    check("rd_ready_low", ready, 0);
    check("rd_req_valid", host_req_valid, 1);
    check("rd_req_wr", host_req_wr, 0);
    check("rd_req_addr", host_req_addr, 64'h1_0001_0040);
    mem_op = 2'b00;
    @(negedge clk);                       // request handshake (rdy=1)
    check("rd_valid_drop", host_req_valid, 0);
    for (int i = 0; i < 8; i++) begin
      host_rsp_valid = 1'b1;
      host_rsp_data  = 64'(i);
      check("rd_no_early_done", tx_done, 0);
      @(negedge clk);
    end
    // Accept edge + 9 edges: RD_REQ, 8 beats, DONE cycle -> 10-cycle latency
    host_rsp_valid = 1'b0;
    check("rd_tx_done", tx_done, 1);
    check("rd_beat0", mem_rd_data[63:0], 0);
    check("rd_beat3", mem_rd_data[255:192], 3);
    check("rd_beat7", mem_rd_data[511:448], 7);
    check("rd_done_ready", ready, 0);
    @(negedge clk);
    check("rd_pulse_end", tx_done, 0);
    check("rd_idle_ready", ready, 1);
    check("rd_held", mem_rd_data[511:448], 7);

    // Reserved op is ignored
    mem_op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsv_ready", ready, 1);
      check("rsv_valid", host_req_valid, 0);
    end
    mem_op = 2'b00;

    // WRITE with host_req_rdy toggling 1,0,1,...
    mem_addr = 32'h0001_0200;
    for (int i = 0; i < 8; i++) line[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i);
    mem_wr_data = line;
    mem_op      = 2'b11;
    @(negedge clk);
    mem_op      = 2'b00;
    mem_wr_data = '0;                     // data must have been latched at accept
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      check("wr_valid", host_req_valid, 1);
      check("wr_wr", host_req_wr, 1);
      check("wr_addr", host_req_addr, 64'h1_0001_0200 + 64'(beat) * 8);
      check("wr_data", host_req_data, 64'hC0DE_0000_0000_0000 | 64'(beat));
      check("wr_no_early_done", tx_done, 0);
      host_req_rdy = (c % 2 == 0);
      @(negedge clk);
      if (host_req_rdy) beat++;
    end
    check("wr_beats", beat, 8);
    host_req_rdy = 1'b1;
    check("wr_tx_done", tx_done, 1);
    check("wr_valid_drop", host_req_valid, 0);
    @(negedge clk);
    check("wr_pulse_end", tx_done, 0);
    check("wr_idle_ready", ready, 1);

    // Reset at RD_DATA beat 3 (unaligned address exercises line alignment)
    mem_addr = 32'h0000_00A7;
    mem_op   = 2'b01;
    @(negedge clk);
    mem_op = 2'b00;
    check("rst2_addr", host_req_addr, 64'h1_0000_0080);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      host_rsp_valid = 1'b1;
      host_rsp_data  = 64'h11 * 64'(i + 1);
      @(negedge clk);
    end
    check("rst2_partial", mem_rd_data[127:64], 64'h22);
    host_rsp_data = 64'h44;
    #2 rst_n = 1'b0;
    #1;
    check("rst2_ready", ready, 1);
    check("rst2_valid", host_req_valid, 0);
    check("rst2_tx_done", tx_done, 0);
    check("rst2_rd", mem_rd_data[127:64], 0);
    check("rst2_addr0", host_req_addr, 0);
    host_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst2_no_done", tx_done, 0);
    end

    // Following READ completes normally
    mem_addr = 32'h0000_00C0;
    mem_op   = 2'b01;
    @(negedge clk);
    mem_op = 2'b00;
    check("rd2_addr", host_req_addr, 64'h1_0000_00C0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      host_rsp_valid = 1'b1;
      host_rsp_data  = 64'h100 + 64'(i);
      @(negedge clk);
    end
    host_rsp_valid = 1'b0;
    check("rd2_tx_done", tx_done, 1);
    check("rd2_beat1", mem_rd_data[127:64], 64'h101);
    check("rd2_beat6", mem_rd_data[447:384], 64'h106);
    @(negedge clk);
    check("rd2_ready", ready, 1);

    // WRITE with host_req_rdy held low
    mem_addr     = 32'h0001_0000;
    mem_wr_data  = line;
    host_req_rdy = 1'b0;
    mem_op       = 2'b11;
    @(negedge clk);
    mem_op = 2'b00;
`ifdef MEM_CTRL_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("tmo_wait", tx_done, 0);
    end
    @(negedge clk);
    check("tmo_tx_done", tx_done, 1);
    check("tmo_err", err, 1);
    check("tmo_valid", host_req_valid, 0);
    @(negedge clk);
    check("tmo_ready", ready, 1);
    check("tmo_err_sticky", err, 1);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("stall_no_done", tx_done, 0);
    end
    check("stall_err", err, 0);
    check("stall_valid", host_req_valid, 1);
    check("stall_data", host_req_data, 64'hC0DE_0000_0000_0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stall_abort_ready", ready, 1);
`endif
    host_req_rdy = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
